// File: rtl/song_pkg.sv
// song_pkg
// Shared definitions for the song sequencer slice:
//   - song_rom word field positions ([15] reserved, [14:9] note, [8:0] duration)
//   - the end-of-song marker word
//   - sequencer state encoding
//   - is_end_marker(): true when note and duration are both zero; the reserved
//     bit does not take part in the match.
package song_pkg;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 0;

    localparam logic [15:0] END_MARKER = 16'h0000;
    localparam logic [15:0] FIELD_MASK = 16'h7FFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_HANDOFF = 3'd3;
    localparam logic [2:0] S_PLAY    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FETCH   = S_FETCH,
        ST_LOAD    = S_LOAD,
        ST_HANDOFF = S_HANDOFF,
        ST_PLAY    = S_PLAY
    } seq_state_t;

    function automatic logic is_end_marker(input logic [15:0] word);
        return (word & FIELD_MASK) == (END_MARKER & FIELD_MASK);
    endfunction

endpackage

// File: rtl/song_beat_counter.sv
// beat_counter
// Loadable down-counter of beat strobes. Decrements once per cycle in which
// active, beat and play are all high; terminal flags a count of 1 so the
// owner can act on the beat that finishes the interval.
// Ports:
//   clk, rst_n  clock, async active-low reset (count -> 0)
//   clear       synchronous clear to 0 (highest priority)
//   load        synchronous load of load_val
//   load_val    value to load
//   active      owner is in its counting phase
//   beat, play  tempo strobe and run level; both must be high to count
//   terminal    count == 1
module beat_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         active,
    input  logic         beat,
    input  logic         play,
    output logic         terminal
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (active && beat && play && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign terminal = (count == ONE);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer
// Walks song_rom, offers each note to the note player over valid/ready and
// holds it for its duration in beats. current_addr only moves when a new note
// is loaded, giving note_display a stable lookahead base for a whole note.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   play          run level (0 pauses beat counting once the note is handed off)
//   rewind        pulse, restart from address 0 (beats everything else)
//   beat          tempo strobe
//   rom_addr      song_rom address (ROM has one cycle read latency)
//   rom_data      song_rom word
//   current_addr  address of the sounding note
//   note          note code of the sounding note
//   note_valid    note offered; note_ready accepts
//   song_done     one-cycle pulse on the end marker
//
// state   | meaning
// IDLE    | stopped, outputs held, waiting for play
// FETCH   | rom_addr presented, waiting out ROM latency
// LOAD    | rom_data valid: end marker or new note
// HANDOFF | note_valid high until note_ready
// PLAY    | counting beats of the current note
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DUR_W  = 9,
    parameter bit LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              rewind,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] current_addr,
    output logic [5:0]        note,
    output logic              note_valid,
    input  logic              note_ready,
    output logic              song_done
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt, current_addr_nxt;
    logic [5:0]        note_nxt;
    logic              note_valid_nxt, song_done_nxt;
    logic              cnt_load, cnt_clear, cnt_terminal;
    logic [DUR_W-1:0]  dur_field, dur_load;

    assign dur_field = rom_data[DUR_MSB:DUR_LSB];
    // A zero duration on a real note still sounds for one beat.
    assign dur_load  = (dur_field == '0) ? DUR_W'(1) : dur_field;

    beat_counter #(.W(DUR_W)) u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (dur_load),
        .active   (state == ST_PLAY),
        .beat     (beat),
        .play     (play),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rom_addr     <= '0;
            current_addr <= '0;
            note         <= '0;
            note_valid   <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            rom_addr     <= rom_addr_nxt;
            current_addr <= current_addr_nxt;
            note         <= note_nxt;
            note_valid   <= note_valid_nxt;
            song_done    <= song_done_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        rom_addr_nxt     = rom_addr;
        current_addr_nxt = current_addr;
        note_nxt         = note;
        note_valid_nxt   = note_valid;
        song_done_nxt    = 1'b0;
        cnt_load         = 1'b0;
        cnt_clear        = 1'b0;

        if (rewind) begin
            // current_addr is left alone until the first note reloads it.
            note_valid_nxt = 1'b0;
            rom_addr_nxt   = '0;
            cnt_clear      = 1'b1;
            state_nxt      = play ? ST_FETCH : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play) state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    if (is_end_marker(rom_data)) begin
                        song_done_nxt = 1'b1;
                        rom_addr_nxt  = '0;
                        if (LOOP) begin
                            state_nxt = ST_FETCH;
                        end else begin
                            current_addr_nxt = '0;
                            state_nxt        = ST_IDLE;
                        end
                    end else begin
                        note_nxt         = rom_data[NOTE_MSB:NOTE_LSB];
                        current_addr_nxt = rom_addr;
                        cnt_load         = 1'b1;
                        note_valid_nxt   = 1'b1;
                        state_nxt        = ST_HANDOFF;
                    end
                end
                ST_HANDOFF: begin
                    if (note_ready) begin
                        note_valid_nxt = 1'b0;
                        state_nxt      = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (beat && play && cnt_terminal) begin
                        rom_addr_nxt = rom_addr + ADDR_W'(1);
                        state_nxt    = ST_FETCH;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          play = 1'b0;
    logic          rewind = 1'b0;
    logic          beat = 1'b0;
    logic          note_ready = 1'b0;
    logic [AW-1:0] rom_addr [2];
    logic [15:0]   rom_data [2];
    logic [AW-1:0] current_addr [2];
    logic [5:0]    note [2];
    logic          note_valid [2];
    logic          song_done [2];
    logic [15:0]   rom [64];

    int checks = 0;
    int errors = 0;

    song_sequencer #(.ADDR_W(AW), .DUR_W(9), .LOOP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .play(play), .rewind(rewind), .beat(beat),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .current_addr(current_addr[0]),
        .note(note[0]), .note_valid(note_valid[0]), .note_ready(note_ready),
        .song_done(song_done[0])
    );

    song_sequencer #(.ADDR_W(AW), .DUR_W(9), .LOOP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .play(play), .rewind(rewind), .beat(beat),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .current_addr(current_addr[1]),
        .note(note[1]), .note_valid(note_valid[1]), .note_ready(note_ready),
        .song_done(song_done[1])
    );

    always #5 clk = ~clk;

    // song_rom stand-in: one-cycle registered read per sequencer
    always @(posedge clk) begin
        rom_data[0] <= rom[rom_addr[0]];
        rom_data[1] <= rom[rom_addr[1]];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] w(input int n, input int d);
        return {1'b0, 6'(n), 9'(d)};
    endfunction

    // ---------------- behavioural model ----------------
    // Tracks where the player is in the song: m_wait counts the cycles left
    // before the fetched word is consumed, m_offer = note waiting for the
    // player, m_sound = note sounding with m_beats beats left.
    int m_addr [2];
    int m_cur [2];
    int m_note [2];
    int m_beats [2];
    int m_wait [2];
    bit m_valid [2];
    bit m_done [2];
    bit m_offer [2];
    bit m_sound [2];

    task automatic model_step(input int i, input bit loop_en);
        logic [15:0] word;
        m_done[i] = 1'b0;
        if (rewind) begin
            m_valid[i] = 1'b0; m_offer[i] = 1'b0; m_sound[i] = 1'b0;
            m_addr[i] = 0; m_beats[i] = 0;
            m_wait[i] = play ? 2 : 0;
        end else if (m_wait[i] == 2) begin
            m_wait[i] = 1;
        end else if (m_wait[i] == 1) begin
            word = rom[m_addr[i]];
            m_wait[i] = 0;
            if (word[14:9] == 6'd0 && word[8:0] == 9'd0) begin
                m_done[i] = 1'b1;
                m_addr[i] = 0;
                if (loop_en) m_wait[i] = 2;
                else m_cur[i] = 0;
            end else begin
                m_note[i]  = int'(word[14:9]);
                m_cur[i]   = m_addr[i];
                m_beats[i] = (word[8:0] == 9'd0) ? 1 : int'(word[8:0]);
                m_valid[i] = 1'b1;
                m_offer[i] = 1'b1;
            end
        end else if (m_offer[i]) begin
            if (note_ready) begin
                m_valid[i] = 1'b0; m_offer[i] = 1'b0; m_sound[i] = 1'b1;
            end
        end else if (m_sound[i]) begin
            if (beat && play) begin
                if (m_beats[i] == 1) begin
                    m_sound[i] = 1'b0;
                    m_addr[i]  = (m_addr[i] + 1) % 64;
                    m_wait[i]  = 2;
                end else begin
                    m_beats[i]--;
                end
            end
        end else if (play) begin
            m_wait[i] = 2;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_addr[i] = 0; m_cur[i] = 0; m_note[i] = 0; m_beats[i] = 0; m_wait[i] = 0;
                m_valid[i] = 1'b0; m_done[i] = 1'b0; m_offer[i] = 1'b0; m_sound[i] = 1'b0;
            end
        end else begin
            model_step(0, 1'b0);
            model_step(1, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rom_addr%0d", i), int'(rom_addr[i]), m_addr[i]);
                chk($sformatf("current_addr%0d", i), int'(current_addr[i]), m_cur[i]);
                chk($sformatf("note%0d", i), int'(note[i]), m_note[i]);
                chk($sformatf("note_valid%0d", i), int'(note_valid[i]), int'(m_valid[i]));
                chk($sformatf("song_done%0d", i), int'(song_done[i]), int'(m_done[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    int cyc_n = 0;
    int ph = 0;
    int period = 10;
    bit beat_en = 1'b0;
    bit rw_on_beat = 1'b0;
    int hs_note0[$];
    int hs_addr0[$];
    int hs_cyc0[$];
    int hs_note1[$];
    int hs_addr1[$];
    int done_cnt [2];

    // Logs the cycle about to be sampled (outputs + final inputs), then
    // advances one negedge and drives beat/rewind for the next edge.
    task automatic cyc();
        if (rst_n) begin
            if (note_valid[0] && note_ready) begin
                hs_note0.push_back(int'(note[0]));
                hs_addr0.push_back(int'(current_addr[0]));
                hs_cyc0.push_back(cyc_n);
            end
            if (note_valid[1] && note_ready) begin
                hs_note1.push_back(int'(note[1]));
                hs_addr1.push_back(int'(current_addr[1]));
            end
            for (int i = 0; i < 2; i++) if (song_done[i]) done_cnt[i]++;
        end
        @(negedge clk);
        cyc_n++;
        rewind = 1'b0;
        if (beat_en) begin
            beat = (ph == period - 1);
            ph = (ph + 1) % period;
        end else begin
            beat = 1'b0;
        end
        if (rw_on_beat && beat) begin
            rewind = 1'b1;
            rw_on_beat = 1'b0;
        end
    endtask

    task automatic begin_reset();
        #2;
        rst_n = 1'b0;
        play = 1'b0; note_ready = 1'b0; beat_en = 1'b0; rw_on_beat = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    task automatic end_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc_n = 0; ph = 0; period = 10;
        hs_note0.delete(); hs_addr0.delete(); hs_cyc0.delete();
        hs_note1.delete(); hs_addr1.delete();
        done_cnt = '{0, 0};
    endtask

    task automatic rom_basic();
        rom[0] = w(5, 2);
        rom[1] = w(7, 1);
        rom[2] = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int stable;

        // ---- reset values, basic song, LOOP=1 restart ----
        begin_reset(); rom_basic(); end_reset();
        chk("rst_note_valid", int'(note_valid[0]), 0);
        chk("rst_rom_addr", int'(rom_addr[0]), 0);
        chk("rst_current_addr", int'(current_addr[0]), 0);
        chk("rst_note", int'(note[0]), 0);
        chk("rst_song_done", int'(song_done[0]), 0);
        note_ready = 1'b1; play = 1'b1; beat_en = 1'b1;
        repeat (31) cyc();
        play = 1'b0;
        repeat (20) cyc();
        chk("t1_hs_count", hs_note0.size(), 2);
        if (hs_note0.size() >= 2) begin
            chk("t1_note_a", hs_note0[0], 5);
            chk("t1_addr_a", hs_addr0[0], 0);
            chk("t1_note_b", hs_note0[1], 7);
            chk("t1_addr_b", hs_addr0[1], 1);
            chk("t1_hold_gap", hs_cyc0[1] - hs_cyc0[0], 20);
        end
        chk("t1_done_cnt", done_cnt[0], 1);
        chk("t1_idle_cur", int'(current_addr[0]), 0);
        chk("t1_idle_valid", int'(note_valid[0]), 0);
        chk("t1_loop_hs_count", hs_note1.size(), 3);
        if (hs_note1.size() >= 3) begin
            chk("t1_loop_note", hs_note1[2], 5);
            chk("t1_loop_addr", hs_addr1[2], 0);
        end
        chk("t1_loop_done_cnt", done_cnt[1], 1);

        // ---- note_ready held low for 20 cycles ----
        begin_reset(); rom_basic(); end_reset();
        note_ready = 1'b0; play = 1'b1; beat_en = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            cyc();
            if (note_valid[0]) seen = 1;
        end
        chk("t2_valid_seen", seen, 1);
        stable = 0;
        for (int k = 0; k < 20; k++) begin
            if (note_valid[0] && note[0] == 6'd5) stable++;
            cyc();
        end
        chk("t2_stable_cycles", stable, 20);
        note_ready = 1'b1;
        repeat (30) cyc();
        chk("t2_hs_count", hs_note0.size(), 2);
        if (hs_note0.size() >= 2) chk("t2_hold_gap", hs_cyc0[1] - hs_cyc0[0], 20);

        // ---- pause across 5 beats of a 3-beat note ----
        begin_reset();
        rom[0] = w(4, 3); rom[1] = w(6, 1); rom[2] = 16'h0000;
        end_reset();
        note_ready = 1'b1; play = 1'b1; beat_en = 1'b1;
        repeat (11) cyc();
        play = 1'b0;
        repeat (50) cyc();
        play = 1'b1;
        repeat (24) cyc();
        chk("t3_hs_count", hs_note0.size(), 2);
        if (hs_note0.size() >= 2) begin
            chk("t3_note_a", hs_note0[0], 4);
            chk("t3_note_b", hs_note0[1], 6);
            chk("t3_pause_gap", hs_cyc0[1] - hs_cyc0[0], 80);
        end

        // ---- rewind coinciding with a beat at address 1 ----
        begin_reset(); rom_basic(); end_reset();
        note_ready = 1'b1; play = 1'b1; beat_en = 1'b1;
        repeat (24) cyc();
        rw_on_beat = 1'b1;
        repeat (7) cyc();
        chk("t4_rw_rom_addr", int'(rom_addr[0]), 0);
        chk("t4_rw_valid", int'(note_valid[0]), 0);
        chk("t4_rw_cur_kept", int'(current_addr[0]), 1);
        repeat (5) cyc();
        chk("t4_hs_count", hs_note0.size(), 3);
        if (hs_note0.size() >= 3) begin
            chk("t4_note", hs_note0[2], 5);
            chk("t4_addr", hs_addr0[2], 0);
            chk("t4_hs_cycle", hs_cyc0[2], 33);
        end
        chk("t4_done_cnt", done_cnt[0], 0);

        // ---- dur=0 note and address wrap with no end marker ----
        begin_reset();
        rom[0] = w(9, 0);
        for (int i = 1; i < 64; i++) rom[i] = w((i % 62) + 1, 1);
        end_reset();
        period = 4;
        note_ready = 1'b1; play = 1'b1; beat_en = 1'b1;
        repeat (280) cyc();
        chk("t5_hs_enough", int'(hs_note0.size() >= 65), 1);
        if (hs_note0.size() >= 65) begin
            chk("t5_first_note", hs_note0[0], 9);
            chk("t5_dur0_gap", hs_cyc0[1] - hs_cyc0[0], 4);
            chk("t5_addr_63", hs_addr0[63], 63);
            chk("t5_addr_wrap", hs_addr0[64], 0);
            chk("t5_wrap_note", hs_note0[64], 9);
        end
        chk("t5_no_done0", done_cnt[0], 0);
        chk("t5_no_done1", done_cnt[1], 0);

        // ---- asynchronous reset mid-HANDOFF ----
        begin_reset(); rom_basic(); end_reset();
        note_ready = 1'b1; play = 1'b1; beat_en = 1'b1;
        repeat (5) cyc();
        note_ready = 1'b0;
        repeat (20) cyc();
        chk("t6_pre_valid", int'(note_valid[0]), 1);
        chk("t6_pre_addr", int'(current_addr[0]), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_rst_valid%0d", i), int'(note_valid[i]), 0);
            chk($sformatf("t6_rst_note%0d", i), int'(note[i]), 0);
            chk($sformatf("t6_rst_cur%0d", i), int'(current_addr[i]), 0);
            chk($sformatf("t6_rst_rom_addr%0d", i), int'(rom_addr[i]), 0);
            chk($sformatf("t6_rst_done%0d", i), int'(song_done[i]), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
